// File: rtl/exc_pkg.sv
// exc_pkg: shared constants and types for the exception/return sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ExcCode values, CP0 Status bit indices, handler vector, FSM state enum.
package exc_pkg;

  // Handler entry address; CP0 owns the real vector, kept here for reference.
  localparam logic [31:0] EXC_VEC = 32'h0040_0004;

  // ExcCode values written to CP0 Cause.
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  // CP0 Status bit positions consulted when qualifying a request.
  localparam int ST_IE      = 0;
  localparam int ST_SYSCALL = 1;
  localparam int ST_BREAK   = 2;
  localparam int ST_TEQ     = 3;
  localparam int ST_IRQ     = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAP  = 2'd1,
    S_REDIR = 2'd2,
    S_ERET  = 2'd3
  } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: qualifies decode-stage trap/ERET/IRQ requests against Status
// Latency: purely combinational.
// Backpressure: none; the caller decides whether a request can be accepted.
// Ports: i_instr_valid, i_is_* instruction class, i_teq_eq, i_status[4:0],
//        i_pending (latched IRQs) -> o_req_vld, o_is_eret, o_is_irq, o_cause, o_irq_idx.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             i_instr_valid,
  input  logic             i_is_syscall,
  input  logic             i_is_break,
  input  logic             i_is_teq,
  input  logic             i_is_eret,
  input  logic             i_teq_eq,
  input  logic [4:0]       i_status,
  input  logic [N_IRQ-1:0] i_pending,
  output logic             o_req_vld,
  output logic             o_is_eret,
  output logic             o_is_irq,
  output logic [4:0]       o_cause,
  output logic [IDX_W-1:0] o_irq_idx
);

  logic w_ie;
  assign w_ie = i_status[ST_IE];

  // The chain is selected by instruction class, not by enable: a masked
  // trap still occupies its priority slot and simply produces no request,
  // so it also hides any pending IRQ behind it.
  always_comb begin
    o_req_vld = 1'b0;
    o_is_eret = 1'b0;
    o_is_irq  = 1'b0;
    o_cause   = EXC_INT;
    o_irq_idx = '0;
    if (i_instr_valid) begin
      if (i_is_eret) begin
        o_req_vld = 1'b1;
        o_is_eret = 1'b1;
      end else if (i_is_syscall) begin
        o_req_vld = w_ie & i_status[ST_SYSCALL];
        o_cause   = EXC_SYSCALL;
      end else if (i_is_break) begin
        o_req_vld = w_ie & i_status[ST_BREAK];
        o_cause   = EXC_BREAK;
      end else if (i_is_teq && i_teq_eq) begin
        o_req_vld = w_ie & i_status[ST_TEQ];
        o_cause   = EXC_TEQ;
      end else if (w_ie && i_status[ST_IRQ] && (|i_pending)) begin
        o_req_vld = 1'b1;
        o_is_irq  = 1'b1;
        // Walk downwards so the lowest set line wins.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
          if (i_pending[i]) o_irq_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// exc_sequencer: sequences CP0 exception/ERET pulses and stalls/redirects fetch.
// Latency: trap -> exception at T+1, pc_redirect at T+2; ERET -> eret+redirect at T+1.
// Backpressure: requests seen outside IDLE are ignored; decode is stalled so they re-present.
// Ports: i_clk, i_rst (async, active-high), decode inputs (i_instr_valid, i_is_*,
//        i_teq_eq, i_pc_in), i_status, i_irq -> o_exception, o_eret, o_cause,
//        o_epc, o_stall, o_pc_redirect, o_busy.
// Build option: define EXC_IRQ_EN to latch and service external interrupts;
// otherwise i_irq and Status bit4 are ignored.
module exc_sequencer
  import exc_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_instr_valid,
  input  logic             i_is_syscall,
  input  logic             i_is_break,
  input  logic             i_is_teq,
  input  logic             i_is_eret,
  input  logic             i_teq_eq,
  input  logic [31:0]      i_pc_in,
  input  logic [31:0]      i_status,
  input  logic [N_IRQ-1:0] i_irq,
  output logic             o_exception,
  output logic             o_eret,
  output logic [4:0]       o_cause,
  output logic [31:0]      o_epc,
  output logic             o_stall,
  output logic             o_pc_redirect,
  output logic             o_busy
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  state_t      r_state;
  logic        r_exception;
  logic        r_eret;
  logic [4:0]  r_cause;
  logic [31:0] r_epc;
  logic        r_stall;
  logic        r_pc_redirect;
  logic        r_busy;

  logic             w_req_vld;
  logic             w_is_eret;
  logic             w_is_irq;
  logic [4:0]       w_cause;
  logic [IDX_W-1:0] w_irq_idx;
  logic [N_IRQ-1:0] w_pending;
  logic             w_take;

  exc_prio_enc #(
    .N_IRQ (N_IRQ),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_instr_valid (i_instr_valid),
    .i_is_syscall  (i_is_syscall),
    .i_is_break    (i_is_break),
    .i_is_teq      (i_is_teq),
    .i_is_eret     (i_is_eret),
    .i_teq_eq      (i_teq_eq),
    .i_status      (i_status[4:0]),
    .i_pending     (w_pending),
    .o_req_vld     (w_req_vld),
    .o_is_eret     (w_is_eret),
    .o_is_irq      (w_is_irq),
    .o_cause       (w_cause),
    .o_irq_idx     (w_irq_idx)
  );

  // A request is only accepted in IDLE; everything else waits for decode to re-present it.
  assign w_take = (r_state == S_IDLE) && w_req_vld;

`ifdef EXC_IRQ_EN
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] w_irq_clr;
  logic             w_unused;

  always_comb begin
    w_irq_clr = '0;
    if (w_take && w_is_irq) w_irq_clr[w_irq_idx] = 1'b1;
  end

  // Clear is applied before the new sample so a line still held high re-pends.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_irq_clr) | i_irq;
    end
  end

  assign w_pending = r_pending;
  assign w_unused  = ^i_status[31:5];
`else
  logic w_unused;

  assign w_pending = '0;
  assign w_unused  = ^{i_irq, i_status[31:5], w_is_irq, w_irq_idx};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_exception   <= 1'b0;
      r_eret        <= 1'b0;
      r_cause       <= EXC_INT;
      r_epc         <= 32'd0;
      r_stall       <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_stall <= 1'b1;
            r_busy  <= 1'b1;
            if (w_is_eret) begin
              r_state       <= S_ERET;
              r_eret        <= 1'b1;
              r_pc_redirect <= 1'b1;
            end else begin
              r_state     <= S_TRAP;
              r_exception <= 1'b1;
              r_cause     <= w_cause;
              r_epc       <= i_pc_in;
            end
          end
        end
        S_TRAP: begin
          // cause/epc are only meaningful alongside the exception pulse.
          r_state       <= S_REDIR;
          r_exception   <= 1'b0;
          r_cause       <= EXC_INT;
          r_epc         <= 32'd0;
          r_pc_redirect <= 1'b1;
        end
        S_REDIR: begin
          r_state       <= S_IDLE;
          r_pc_redirect <= 1'b0;
          r_stall       <= 1'b0;
          r_busy        <= 1'b0;
        end
        S_ERET: begin
          r_state       <= S_IDLE;
          r_eret        <= 1'b0;
          r_pc_redirect <= 1'b0;
          r_stall       <= 1'b0;
          r_busy        <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_exception   = r_exception;
  assign o_eret        = r_eret;
  assign o_cause       = r_cause;
  assign o_epc         = r_epc;
  assign o_pc_redirect = r_pc_redirect;
  assign o_busy        = r_busy;
  // Detect-cycle stall is combinational; gated by reset so reset forces all outputs low.
  assign o_stall       = r_stall | (w_take & ~i_rst);

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception/return sequencer in front of the CP0 register file. Decodes trap conditions (SYSCALL, BREAK, taken TEQ), ERET, and optionally latched external interrupts, and filters them against the CP0 Status word. It then drives CP0's `exception`/`eret`/`cause`/`pc` inputs as single-cycle pulses and stalls and redirects the fetch stage while the CP0 update completes. It sits between the decode stage and CP0; the PC mux takes CP0 `exc_addr` whenever `pc_redirect` is high.

## Interface
- `EXC_VEC`, 32'h0040_0004: handler entry address. Informational only; CP0 supplies the actual vector.
- `N_IRQ`, 4: number of external interrupt lines. Used only when the IRQ feature is compiled in.

Ports:
- `clk`  in  1  — the single clock; all state changes on its rising edge.
- `rst`  in  1  — reset; asynchronous and active-high.
- `instr_valid`  in  1  — the decode-stage instruction is real (not a bubble).
- `is_syscall`, `is_break`, `is_teq`, `is_eret`  in  1 each  — decoded instruction class.
- `teq_eq`  in  1  — rs==rt comparison result for TEQ.
- `pc_in`  in  32  — PC of the decode-stage instruction.
- `status`  in  32  — CP0 Status (reg 12).
- `irq`  in  N_IRQ  — external interrupt lines, level, synchronous to `clk`.
- `exception`  out  1  — pulse to CP0 `exception`.
- `eret`  out  1  — to CP0 `eret`.
- `cause`  out  5  — ExcCode to CP0.
- `epc`  out  32  — PC to CP0.
- `stall`  out  1  — freeze PC and decode.
- `pc_redirect`  out  1  — PC mux selects CP0 `exc_addr`.
- `busy`  out  1  — FSM not in IDLE.

## Operation
- ExcCodes: INT=0, SYSCALL=8, BREAK=9, TEQ=13.
- Status bits used: bit0 = global IE; bit1 = SYSCALL enable, bit2 = BREAK enable, bit3 = TEQ enable, bit4 = IRQ enable. A source is taken only when bit0 and its own bit are both 1. CP0 shifts Status left by 5 on entry, which masks nested traps inside the handler.
- Request qualification in IDLE, with `instr_valid`=1, in priority order: ERET > SYSCALL > BREAK > TEQ (requires `teq_eq`) > pending IRQ (lowest index first).
  - A masked trap is treated as a NOP: no pulse and no stall.
  - ERET is never masked.
- FSM states: IDLE, TRAP, REDIR, ERET.
  - IDLE → TRAP on a qualified trap or IRQ. On entry, capture `cause` and `epc`=`pc_in`.
  - TRAP → REDIR unconditionally.
  - REDIR → IDLE unconditionally.
  - IDLE → ERET on a qualified ERET.
  - ERET → IDLE unconditionally.
- Outputs per state:
  - IDLE: all outputs 0, except `stall`. `stall` is combinationally 1 in the detect cycle when a qualified request is present.
  - TRAP: `exception`=1, `stall`=1, `busy`=1, registered `cause`/`epc` valid.
  - REDIR: `pc_redirect`=1, `stall`=1, `busy`=1. CP0 `exc_addr` = vector.
  - ERET: `eret`=1, `pc_redirect`=1, `stall`=1, `busy`=1. CP0 `exc_addr` = EPC+4 in the same cycle.
- Requests arriving while not in IDLE are ignored. Decode is stalled, so the instruction is re-presented after return to IDLE.
- Reset: FSM → IDLE. All outputs 0, `cause`=0, `epc`=0, IRQ pending cleared. Reset in any state aborts the sequence immediately; no partial pulse follows reset deassertion.

## Timing
- Trap detected in cycle T: `exception` high in T+1; `pc_redirect` high in T+2; first handler fetch in T+3.
- ERET detected in T: `eret` and `pc_redirect` high in T+1; return fetch in T+2.
- `exception` and `eret` are each exactly 1 cycle wide and never high together.

## Configuration
- `EXC_IRQ_EN` defined:
  - `irq` is sampled every cycle into the `pending` register (a bit is set on level-high).
  - A pending bit is cleared in the cycle its interrupt enters TRAP.
  - An IRQ is qualified only when `instr_valid`=1 and no instruction trap is present. EPC is the interrupted instruction's PC.
- `EXC_IRQ_EN` undefined: the `irq` port is ignored, no pending register exists, and Status bit4 is unused.

## Structure
- Shared package `exc_pkg`:
  - ExcCode constants (`EXC_INT`, `EXC_SYSCALL`, `EXC_BREAK`, `EXC_TEQ`).
  - Status bit-index constants.
  - FSM state enum.
- One sub-module `exc_prio_enc`: combinational priority encoder producing request-valid, cause, IRQ index, and is_eret.

## Test plan
- Status=0x0F, SYSCALL at pc 0x0040_0100 → T+1: `exception`=1, `cause`=8, `epc`=0x0040_0100; T+2: `pc_redirect`=1; `stall` high T..T+2.
- Status=0x0B (BREAK disabled), BREAK → no `exception`, no `stall`. Then TEQ with `teq_eq`=1 → `cause`=13. With `teq_eq`=0 → nothing.
- Status=0x00 (handler context after CP0's shift), ERET → T+1: `eret`=1 and `pc_redirect`=1 for exactly one cycle; `busy` back to 0 in T+2.
- SYSCALL held present while FSM is in TRAP/REDIR → exactly one `exception` pulse per presentation; re-presented SYSCALL in IDLE traps again.
- `rst` asserted in TRAP → all outputs 0 asynchronously; after release, no `pc_redirect` occurs.
- `EXC_IRQ_EN`, Status=0x11, `irq`=4'b0110 for 1 cycle → `cause`=0 taken for line 1 first, then line 2 on the next valid IDLE instruction; pending becomes 0.
